// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signal bundle for the two-requester APB master.
// The master modport is the arbiter's view; the slave modport is the far side
// (requesters plus the APB slave) as seen by whatever drives them.
interface apb_master_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // requester 0
   logic              req0_valid;
   logic              req0_write;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_done;
   logic              req0_err;
   logic [DATA_W-1:0] req0_rdata;
   // requester 1
   logic              req1_valid;
   logic              req1_write;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_done;
   logic              req1_err;
   logic [DATA_W-1:0] req1_rdata;
   // APB
   logic              PSEL;
   logic              PENABLE;
   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;

   modport master (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      output req0_done, req0_err, req0_rdata,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req1_done, req1_err, req1_rdata,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      input  PREADY, PRDATA
   );

   modport slave (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      input  req0_done, req0_err, req0_rdata,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req1_done, req1_err, req1_rdata,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      output PREADY, PRDATA
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sharing one APB slave port between two requesters.
// Latency: grant at edge k, SETUP k+1, ACCESS k+2, done pulse in cycle k+3 at the earliest.
// Backpressure: PREADY low stretches ACCESS up to TIMEOUT cycles, then aborts with err.
module apb_master_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   apb_master_arbiter_if.master bus
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t            state_q,      state_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              gnt_q,        gnt_d;
   logic              psel_q,       psel_d;
   logic              penable_q,    penable_d;
   logic [ADDR_W-1:0] paddr_q,      paddr_d;
   logic              pwrite_q,     pwrite_d;
   logic [DATA_W-1:0] pwdata_q,     pwdata_d;
   logic              done0_q,      done0_d;
   logic              done1_q,      done1_d;
   logic              err0_q,       err0_d;
   logic              err1_q,       err1_d;
   logic [DATA_W-1:0] rdata0_q,     rdata0_d;
   logic [DATA_W-1:0] rdata1_q,     rdata1_d;

   logic elig0, elig1, pick1;

   // A requester whose done pulse is showing this cycle is still holding valid; mask it.
   assign elig0 = bus.req0_valid & ~done0_q;
   assign elig1 = bus.req1_valid & ~done1_q;
   // On a tie pick the requester that was not granted last time.
   assign pick1 = elig1 & (~elig0 | ~last_grant_q);

   // Next-state and registered-output computation for the IDLE/SETUP/ACCESS sequence.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      paddr_d      = paddr_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;

      case (state_q)
         ST_IDLE: begin
            if (elig0 | elig1) begin
               state_d      = ST_SETUP;
               gnt_d        = pick1;
               last_grant_d = pick1;
               cnt_d        = '0;
               psel_d       = 1'b1;
               penable_d    = 1'b0;
               paddr_d      = pick1 ? bus.req1_addr  : bus.req0_addr;
               pwrite_d     = pick1 ? bus.req1_write : bus.req0_write;
               pwdata_d     = pick1 ? bus.req1_wdata : bus.req0_wdata;
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (bus.PREADY) begin
               state_d   = ST_IDLE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (gnt_q) begin
                  done1_d = 1'b1;
                  if (!pwrite_q) rdata1_d = bus.PRDATA;
               end else begin
                  done0_d = 1'b1;
                  if (!pwrite_q) rdata0_d = bus.PRDATA;
               end
            end else if (cnt_q == CNT_LAST) begin
               // Slave never answered: release the bus and report the abort.
               state_d   = ST_IDLE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (gnt_q) begin
                  done1_d = 1'b1;
                  err1_d  = 1'b1;
               end else begin
                  done0_d = 1'b1;
                  err0_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight transfer silently.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         paddr_q      <= '0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         paddr_q      <= paddr_d;
         pwrite_q     <= pwrite_d;
         pwdata_q     <= pwdata_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign bus.PSEL       = psel_q;
   assign bus.PENABLE    = penable_q;
   assign bus.PADDR      = paddr_q;
   assign bus.PWRITE     = pwrite_q;
   assign bus.PWDATA     = pwdata_q;
   assign bus.req0_done  = done0_q;
   assign bus.req0_err   = err0_q;
   assign bus.req0_rdata = rdata0_q;
   assign bus.req1_done  = done1_q;
   assign bus.req1_err   = err1_q;
   assign bus.req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: per-cycle vector table plus hand sequences
// for wait states, timeout abort and reset in the middle of a transfer.
module tb_apb_master_arbiter;

   logic clk;
   logic rst;

   apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .PCLK   (clk),
      .PRESET (rst),
      .bus    (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        r0v;  logic r0w;  logic [31:0] r0a;  logic [31:0] r0d;
      logic        r1v;  logic r1w;  logic [31:0] r1a;  logic [31:0] r1d;
      logic        prdy; logic [31:0] prd;
      logic        psel; logic pen;  logic [31:0] pa;   logic pw; logic [31:0] pwd;
      logic [3:0]  hs;   // {done0, done1, err0, err1}
      logic [31:0] rd0;  logic [31:0] rd1;
   } vec_t;

   localparam logic [31:0] A0  = 32'h10, D0  = 32'hCAFE;
   localparam logic [31:0] AR0 = 32'h20, AW1 = 32'h30, DW1 = 32'h55;
   localparam logic [31:0] PX  = 32'hAAAA, PR = 32'hBEEF;

   vec_t vecs [15];

   function automatic vec_t mk(
      input logic r0v, input logic r0w, input logic [31:0] r0a, input logic [31:0] r0d,
      input logic r1v, input logic r1w, input logic [31:0] r1a, input logic [31:0] r1d,
      input logic prdy, input logic [31:0] prd,
      input logic psel, input logic pen, input logic [31:0] pa, input logic pw,
      input logic [31:0] pwd, input logic [3:0] hs, input logic [31:0] rd0,
      input logic [31:0] rd1);
      vec_t v;
      v.r0v = r0v; v.r0w = r0w; v.r0a = r0a; v.r0d = r0d;
      v.r1v = r1v; v.r1w = r1w; v.r1a = r1a; v.r1d = r1d;
      v.prdy = prdy; v.prd = prd;
      v.psel = psel; v.pen = pen; v.pa = pa; v.pw = pw; v.pwd = pwd;
      v.hs = hs; v.rd0 = rd0; v.rd1 = rd1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d;
   endtask

   task automatic set_req1(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d;
   endtask

   initial begin
      int   acc;
      int   cyc;
      logic got;

      // Per-cycle vectors: inputs applied before an edge, outputs checked after it.
      // Single write from req0, held valid through its done cycle, then released.
      vecs[0]  = mk(1,1,A0,D0,    0,0,0,0,       1,PX, 1,0,A0,1,D0,   4'b0000, 0,0);
      vecs[1]  = mk(1,1,A0,D0,    0,0,0,0,       1,PX, 1,1,A0,1,D0,   4'b0000, 0,0);
      vecs[2]  = mk(1,1,A0,D0,    0,0,0,0,       1,PX, 0,0,A0,1,D0,   4'b1000, 0,0);
      vecs[3]  = mk(1,1,A0,D0,    0,0,0,0,       1,PX, 0,0,A0,1,D0,   4'b0000, 0,0);
      vecs[4]  = mk(0,1,A0,D0,    0,0,0,0,       1,PX, 0,0,A0,1,D0,   4'b0000, 0,0);
      // Contention: req0 reads, req1 writes, both held continuously; last grant was req0.
      vecs[5]  = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PX, 1,0,AW1,1,DW1, 4'b0000, 0,0);
      vecs[6]  = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PX, 1,1,AW1,1,DW1, 4'b0000, 0,0);
      vecs[7]  = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PX, 0,0,AW1,1,DW1, 4'b0100, 0,0);
      vecs[8]  = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PX, 1,0,AR0,0,0,   4'b0000, 0,0);
      vecs[9]  = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PX, 1,1,AR0,0,0,   4'b0000, 0,0);
      vecs[10] = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PR, 0,0,AR0,0,0,   4'b1000, PR,0);
      vecs[11] = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PX, 1,0,AW1,1,DW1, 4'b0000, PR,0);
      vecs[12] = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PX, 1,1,AW1,1,DW1, 4'b0000, PR,0);
      vecs[13] = mk(1,0,AR0,0,    1,1,AW1,DW1,   1,PX, 0,0,AW1,1,DW1, 4'b0100, PR,0);
      vecs[14] = mk(0,0,AR0,0,    0,1,AW1,DW1,   1,PX, 0,0,AW1,1,DW1, 4'b0000, PR,0);

      // Reset state
      rst = 1'b1;
      set_req0(0, 0, 0, 0);
      set_req1(0, 0, 0, 0);
      bus.PREADY = 1'b0;
      bus.PRDATA = '0;
      tick();
      tick();
      chk("rst PSEL",    bus.PSEL, 0);
      chk("rst PENABLE", bus.PENABLE, 0);
      chk("rst PADDR",   bus.PADDR, 0);
      chk("rst PWRITE",  bus.PWRITE, 0);
      chk("rst PWDATA",  bus.PWDATA, 0);
      chk("rst hs",      {bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err}, 0);
      chk("rst rdata0",  bus.req0_rdata, 0);
      chk("rst rdata1",  bus.req1_rdata, 0);
      rst = 1'b0;

      // Vector table
      for (int i = 0; i < 15; i++) begin
         set_req0(vecs[i].r0v, vecs[i].r0w, vecs[i].r0a, vecs[i].r0d);
         set_req1(vecs[i].r1v, vecs[i].r1w, vecs[i].r1a, vecs[i].r1d);
         bus.PREADY = vecs[i].prdy;
         bus.PRDATA = vecs[i].prd;
         tick();
         chk($sformatf("v%0d PSEL", i),    bus.PSEL,    vecs[i].psel);
         chk($sformatf("v%0d PENABLE", i), bus.PENABLE, vecs[i].pen);
         chk($sformatf("v%0d PADDR", i),   bus.PADDR,   vecs[i].pa);
         chk($sformatf("v%0d PWRITE", i),  bus.PWRITE,  vecs[i].pw);
         chk($sformatf("v%0d PWDATA", i),  bus.PWDATA,  vecs[i].pwd);
         chk($sformatf("v%0d done/err", i),
             {bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err}, vecs[i].hs);
         chk($sformatf("v%0d rdata0", i),  bus.req0_rdata, vecs[i].rd0);
         chk($sformatf("v%0d rdata1", i),  bus.req1_rdata, vecs[i].rd1);
      end

      // Read from req1 with three PREADY-low ACCESS cycles: done 6 edges after valid.
      set_req1(1, 0, 32'h04, 0);
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h1234;
      acc = 0;
      cyc = 0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         cyc++;
         if (bus.req1_done) begin
            got = 1'b1;
         end else begin
            chk("rdw PSEL held", bus.PSEL, 1);
            if (bus.PENABLE) begin
               acc++;
               chk("rdw PADDR stable",  bus.PADDR, 32'h04);
               chk("rdw PWRITE stable", bus.PWRITE, 0);
               if (acc == 4) bus.PREADY = 1'b1;
            end
         end
      end
      chk("rdw done seen", got, 1);
      chk("rdw latency",   cyc, 6);
      chk("rdw rdata1",    bus.req1_rdata, 32'h1234);
      chk("rdw err1",      bus.req1_err, 0);
      chk("rdw done0",     bus.req0_done, 0);
      chk("rdw rdata0",    bus.req0_rdata, PR);
      set_req1(0, 0, 32'h04, 0);
      tick();

      // Timeout: PREADY never rises, expect 16 ACCESS cycles then an error done.
      set_req0(1, 1, 32'h40, 32'h77);
      bus.PREADY = 1'b0;
      acc = 0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         tick();
         if (bus.req0_done) begin
            got = 1'b1;
         end else begin
            chk("to PSEL held", bus.PSEL, 1);
            if (bus.PENABLE) begin
               acc++;
               chk("to PADDR stable",  bus.PADDR, 32'h40);
               chk("to PWDATA stable", bus.PWDATA, 32'h77);
            end
         end
      end
      chk("to done seen",     got, 1);
      chk("to access cycles", acc, 16);
      chk("to err0",          bus.req0_err, 1);
      chk("to PSEL released", {bus.PSEL, bus.PENABLE}, 0);
      chk("to done1",         {bus.req1_done, bus.req1_err}, 0);
      chk("to rdata0 kept",   bus.req0_rdata, PR);
      tick();
      chk("to pulse width",   {bus.req0_done, bus.req0_err}, 0);
      chk("to no regrant",    bus.PSEL, 0);
      set_req0(0, 1, 32'h40, 32'h77);
      tick();

      // Reset mid-ACCESS: transfer dropped, then req0 wins the first tie.
      set_req0(1, 0, 32'h50, 0);
      set_req1(1, 1, 32'h60, 32'h66);
      bus.PREADY = 1'b0;
      tick();
      tick();
      tick();
      chk("mid PSEL/PENABLE", {bus.PSEL, bus.PENABLE}, 2'b11);
      chk("mid PADDR",        bus.PADDR, 32'h60);
      rst = 1'b1;
      tick();
      chk("rst2 PSEL/PENABLE", {bus.PSEL, bus.PENABLE}, 0);
      chk("rst2 no done",      {bus.req0_done, bus.req1_done}, 0);
      chk("rst2 rdata0",       bus.req0_rdata, 0);
      rst = 1'b0;
      tick();
      chk("tie PSEL",   {bus.PSEL, bus.PENABLE}, 2'b10);
      chk("tie PADDR",  bus.PADDR, 32'h50);
      chk("tie PWRITE", bus.PWRITE, 0);
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'h9999;
      tick();
      tick();
      chk("tie done",   {bus.req0_done, bus.req1_done, bus.req0_err}, 3'b100);
      chk("tie rdata0", bus.req0_rdata, 32'h9999);
      set_req0(0, 0, 32'h50, 0);
      set_req1(0, 1, 32'h60, 32'h66);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
